alu_mult_seq: RTL and testbench

//  Multi-cycle MULT/MULTU sequencer. It time-shares the 32-bit ALU adder to run shift-add

---
 rtl/alu_mult_seq_if.sv | 29 ++
 rtl/alu_mult_seq.sv | 143 ++++++++++++++
 tb/tb_alu_mult_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_mult_seq_if.sv
// Bus between the multiply sequencer and its neighbours: the request/result
// handshake toward the execute stage plus the shared ALU operand/result lines.
interface alu_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] alu_word1;
    logic [WIDTH-1:0] alu_word2;
    logic [1:0]       alu_ALUOp;
    logic             alu_bitinvert;
    logic [WIDTH-1:0] alu_out;

    modport slave (
        input  start, is_signed, op_a, op_b, alu_out,
        output busy, done, hi, lo, alu_word1, alu_word2, alu_ALUOp, alu_bitinvert
    );

    modport master (
        output start, is_signed, op_a, op_b, alu_out,
        input  busy, done, hi, lo, alu_word1, alu_word2, alu_ALUOp, alu_bitinvert
    );
endinterface

// File: rtl/alu_mult_seq.sv
// MULT/MULTU sequencer: shift-add multiply that borrows the execute-stage ALU
// adder, with sign handling done by negating operands and the final product.
module alu_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_mult_seq_if.slave bus
);
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_b_q, neg_b_d;
    logic             lo_zero_q, lo_zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] word1, word2;
    logic             bitinvert;
    logic             carry;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            neg_b_q   <= 1'b0;
            lo_zero_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            neg_res_q <= neg_res_d;
            neg_b_q   <= neg_b_d;
            lo_zero_q <= lo_zero_d;
            cnt_q     <= cnt_d;
        end
    end

    // ALU operand drive depends only on registered state, so the adder result
    // can be folded back into next-state logic without a combinational loop.
    always_comb begin
        word1     = '0;
        word2     = '0;
        bitinvert = 1'b0;
        case (state_q)
            S_NEG_A: begin
                word2     = mcand_q;
                bitinvert = 1'b1;
            end
            S_NEG_B, S_FIX_LO: begin
                word2     = lo_q;
                bitinvert = 1'b1;
            end
            S_ITER: begin
                word1 = hi_q;
                word2 = lo_q[0] ? mcand_q : '0;
            end
            S_FIX_HI: begin
                if (lo_zero_q) begin
                    word2     = hi_q;
                    bitinvert = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        neg_res_d = neg_res_q;
        neg_b_d   = neg_b_q;
        lo_zero_d = lo_zero_q;
        cnt_d     = cnt_q;
        // Carry-out of the partial sum, rebuilt from operand MSBs and sum MSB.
        carry     = (word1[WIDTH-1] & word2[WIDTH-1]) |
                    ((word1[WIDTH-1] | word2[WIDTH-1]) & ~bus.alu_out[WIDTH-1]);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d   = bus.op_a;
                    lo_d      = bus.op_b;
                    hi_d      = '0;
                    cnt_d     = '0;
                    neg_res_d = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                    neg_b_d   = bus.is_signed & bus.op_b[WIDTH-1];
                    if (bus.is_signed && bus.op_a[WIDTH-1])      state_d = S_NEG_A;
                    else if (bus.is_signed && bus.op_b[WIDTH-1]) state_d = S_NEG_B;
                    else                                         state_d = S_ITER;
                end
            end
            S_NEG_A: begin
                mcand_d = bus.alu_out;
                state_d = neg_b_q ? S_NEG_B : S_ITER;
            end
            S_NEG_B: begin
                lo_d    = bus.alu_out;
                state_d = S_ITER;
            end
            S_ITER: begin
                {hi_d, lo_d} = {carry, bus.alu_out, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) state_d = neg_res_q ? S_FIX_LO : S_DONE;
            end
            S_FIX_LO: begin
                lo_zero_d = (lo_q == '0);
                lo_d      = bus.alu_out;
                state_d   = S_FIX_HI;
            end
            S_FIX_HI: begin
                // Two's-complement negate of {hi,lo}: hi takes the carry only when lo was zero.
                hi_d    = lo_zero_q ? bus.alu_out : ~hi_q;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.hi            = hi_q;
    assign bus.lo            = lo_q;
    assign bus.alu_word1     = word1;
    assign bus.alu_word2     = word2;
    assign bus.alu_ALUOp     = 2'b10;
    assign bus.alu_bitinvert = bitinvert;
endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: external ALU adder model, job-level timeline model
// checked every cycle, plus directed literal cases and random jobs.
module tb_alu_mult_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_mult_seq_if #(.WIDTH(W)) ifc ();

    assign ifc.alu_out = ifc.alu_word1 +
                         (ifc.alu_bitinvert ? (~ifc.alu_word2 + 32'd1) : ifc.alu_word2);

    alu_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({32'd0, a}) * longint'({32'd0, b});
        return 64'(p);
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        int l = 33;
        if (s && a[31]) l++;
        if (s && b[31]) l++;
        if (s && (a[31] != b[31])) l += 2;
        return l;
    endfunction

    // Timeline model: m_rem counts cycles left until and including DONE.
    int          m_rem  = 0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_pend = '0;
    bit          m_init = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_rem  <= 0;
            m_prod <= '0;
            m_init <= 1'b1;
        end else if (m_rem == 0) begin
            if (ifc.start) begin
                m_rem  <= ref_lat(ifc.op_a, ifc.op_b, ifc.is_signed);
                m_pend <= ref_prod(ifc.op_a, ifc.op_b, ifc.is_signed);
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) m_prod <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("busy", 64'(ifc.busy), 64'(m_rem != 0));
            chk("done", 64'(ifc.done), 64'(m_rem == 1));
            chk("aluop", 64'(ifc.alu_ALUOp), 64'(2'b10));
            if (m_rem <= 1) begin
                chk("hilo", {ifc.hi, ifc.lo}, m_prod);
                chk("alu_idle_w1", 64'(ifc.alu_word1), 64'd0);
                chk("alu_idle_w2", 64'(ifc.alu_word2), 64'd0);
                chk("alu_idle_inv", 64'(ifc.alu_bitinvert), 64'd0);
            end
        end
    end

    // Call at posedge+2 of the start cycle; returns at posedge+2 of the cycle after DONE.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp_p, input int exp_lat, input string name);
        int cyc;
        bit got;
        ifc.start     = 1'b1;
        ifc.op_a      = a;
        ifc.op_b      = b;
        ifc.is_signed = s;
        @(posedge clk); #2;
        ifc.start     = 1'b0;
        ifc.op_a      = $urandom;
        ifc.op_b      = $urandom;
        ifc.is_signed = 1'($urandom);
        cyc = 1;
        got = 1'b0;
        while (cyc <= 60 && !got) begin
            @(negedge clk);
            if (ifc.done) got = 1'b1;
            else begin
                @(posedge clk); #2;
                cyc++;
            end
        end
        chk({name, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({name, "_prod"}, {ifc.hi, ifc.lo}, exp_p);
        @(posedge clk); #2;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          nd, dc;
        ifc.start     = 1'b0;
        ifc.is_signed = 1'b0;
        ifc.op_a      = '0;
        ifc.op_b      = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_done", 64'(ifc.done), 64'd0);
        chk("rst_hilo", {ifc.hi, ifc.lo}, 64'd0);
        @(posedge clk); #2;

        run_job(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 33, "mulu_7x6");
        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33, "mulu_max");
        run_job(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 36, "mul_m3x5");
        run_job(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 35, "mul_min");
        run_job(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h7FFF_FFFF_8000_0000, 33, "mulu_min");
        run_job(32'hFFFF_FFFC, 32'h4000_0000, 1'b1, 64'hFFFF_FFFF_0000_0000, 36, "mul_lozero");
        run_job(32'd5, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 36, "mul_5xm3");

        // Start pulsed mid-job must be ignored.
        ifc.start = 1'b1; ifc.is_signed = 1'b0; ifc.op_a = 32'd7; ifc.op_b = 32'd6;
        nd = 0; dc = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #2;
            ifc.start = (c == 10);
            if (c == 10) begin ifc.op_a = 32'd3; ifc.op_b = 32'd3; end
            @(negedge clk);
            if (ifc.done) begin nd++; dc = c; end
        end
        chk("ign_done_cnt", 64'(nd), 64'd1);
        chk("ign_done_cyc", 64'(dc), 64'd33);
        chk("ign_prod", {ifc.hi, ifc.lo}, 64'h2A);
        @(posedge clk); #2;

        // Reset mid-job aborts with no done pulse.
        ifc.start = 1'b1; ifc.is_signed = 1'b1; ifc.op_a = 32'hFFFF_FFF0; ifc.op_b = 32'd9;
        nd = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #2;
            ifc.start = 1'b0;
            reset     = (c == 15);
            @(negedge clk);
            if (ifc.done) nd++;
            if (c == 16) begin
                chk("abort_busy", 64'(ifc.busy), 64'd0);
                chk("abort_hilo", {ifc.hi, ifc.lo}, 64'd0);
            end
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        @(posedge clk); #2;
        run_job(32'd12, 32'd11, 1'b0, 64'd132, 33, "after_abort");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'd0;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h8000_0000;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                default: b = $urandom;
            endcase
            s = 1'($urandom);
            run_job(a, b, s, ref_prod(a, b, s), ref_lat(a, b, s), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
